// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response and byte-wide RAM signals of mem_ctrl
// master: requester + RAM side (drives requests and ram_din); slave: mem_ctrl itself.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_inst;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic              mem_sign;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              busy;
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_len, mem_sign, mem_addr, mem_wdata, ram_din,
    input  if_done, if_inst, mem_done, mem_rdata, ram_a, ram_wr, ram_dout, busy
  );
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_len, mem_sign, mem_addr, mem_wdata, ram_din,
    output if_done, if_inst, mem_done, mem_rdata, ram_a, ram_wr, ram_dout, busy
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM sequencer arbitrating instruction fetch and load/store accesses
// Ports: clk, rst (sync, active-high); bus (mem_ctrl_if.slave): fetch req/addr/done/inst,
//   load/store req/we/len/sign/addr/wdata/done/rdata, RAM a/wr/dout/din, busy.
// MEMCTRL_FETCH_ABORT_EN: adds input if_abort, which drops an in-flight fetch.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
`ifdef MEMCTRL_FETCH_ABORT_EN
  input logic if_abort,
`endif
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t            r_state, w_next;
  logic [2:0]        r_cnt, r_n, w_len_n;
  logic              r_is_mem, r_sign, r_if_done, r_mem_done;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_wdata, r_buf, r_if_inst, r_mem_rdata, w_buf, w_ext;
  logic              w_abort, w_acc_mem, w_acc_if, w_kill, w_drive;
`ifdef MEMCTRL_FETCH_ABORT_EN
  assign w_abort = if_abort;
`else
  assign w_abort = 1'b0;
`endif
  // a requester still showing its done pulse must not be re-accepted on the same request
  assign w_acc_mem = bus.mem_req && !r_mem_done;
  assign w_acc_if  = bus.if_req && !r_if_done && !w_abort;
  assign w_kill    = r_state == READ && !r_is_mem && w_abort;
  assign w_len_n   = bus.mem_len == 2'd0 ? 3'd1 : bus.mem_len == 2'd1 ? 3'd2 : 3'd4;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc_mem ? (bus.mem_we ? WRITE : READ) : (w_acc_if ? READ : IDLE);
      READ:    w_next = (w_kill || r_cnt == r_n) ? IDLE : READ;
      WRITE:   w_next = (r_cnt == r_n - 3'd1) ? IDLE : WRITE;
      default: w_next = IDLE;
    endcase
  end
  // ram_din lags the address by one cycle, so cycle c delivers byte c-1
  always_comb begin
    w_buf = r_buf;
    if (r_cnt != 3'd0) w_buf[{r_cnt[1:0] - 2'd1, 3'b000} +: 8] = bus.ram_din;
  end
  assign w_ext = r_n == 3'd1 ? {{24{r_sign & w_buf[7]}}, w_buf[7:0]} :
                 r_n == 3'd2 ? {{16{r_sign & w_buf[15]}}, w_buf[15:0]} : w_buf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 3'd0;
      r_n         <= 3'd0;
      r_is_mem    <= 1'b0;
      r_sign      <= 1'b0;
      r_base      <= '0;
      r_wdata     <= 32'd0;
      r_buf       <= 32'd0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_inst   <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      r_cnt      <= (r_state == IDLE || w_next == IDLE) ? 3'd0 : r_cnt + 3'd1;
      if (r_state == IDLE) begin
        r_buf <= 32'd0;
        if (w_acc_mem) begin
          r_is_mem <= 1'b1;
          r_base   <= bus.mem_addr;
          r_n      <= w_len_n;
          r_sign   <= bus.mem_sign;
          r_wdata  <= bus.mem_wdata;
        end else if (w_acc_if) begin
          r_is_mem <= 1'b0;
          r_base   <= bus.if_addr;
          r_n      <= 3'd4;
          r_sign   <= 1'b0;
        end
      end else if (r_state == READ) begin
        r_buf <= w_buf;
        if (w_next == IDLE && !w_kill) begin
          if (r_is_mem) begin
            r_mem_done  <= 1'b1;
            r_mem_rdata <= w_ext;
          end else begin
            r_if_done <= 1'b1;
            r_if_inst <= w_buf;
          end
        end
      end else if (w_next == IDLE) r_mem_done <= 1'b1;
    end
  end
  assign w_drive      = r_state == WRITE || (r_state == READ && r_cnt != r_n);
  assign bus.ram_a    = w_drive ? r_base + ADDR_W'(r_cnt) : '0;
  assign bus.ram_wr   = r_state == WRITE;
  assign bus.ram_dout = r_state == WRITE ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'd0;
  assign bus.busy      = r_state != IDLE;
  assign bus.if_done   = r_if_done;
  assign bus.if_inst   = r_if_inst;
  assign bus.mem_done  = r_mem_done;
  assign bus.mem_rdata = r_mem_rdata;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: vector table, corner sequences and random traffic against a byte-array RAM model
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef MEMCTRL_FETCH_ABORT_EN
  logic if_abort = 1'b0;
`endif
  int total = 0;
  int bad = 0;
  mem_ctrl_if #(.ADDR_W(32)) b();
  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MEMCTRL_FETCH_ABORT_EN
    .if_abort(if_abort),
`endif
    .bus(b)
  );
  always #5 clk = ~clk;
  logic [7:0] ram [logic [31:0]];
  logic [7:0] mdl [logic [31:0]];
  function automatic logic [7:0] rd(logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction
  function automatic logic [7:0] md(logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : 8'h00;
  endfunction
  always @(posedge clk) begin
    b.ram_din <= rd(b.ram_a);
    if (b.ram_wr) ram[b.ram_a] = b.ram_dout;
  end
  task automatic pre(input logic [31:0] a, input logic [7:0] v);
    ram[a] = v;
    mdl[a] = v;
  endtask
  function automatic int nb(logic [1:0] len);
    return len == 2'd0 ? 1 : len == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic [31:0] m_load(logic [31:0] a, int n, bit s);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v + (32'(md(a + 32'(i))) << (8 * i));
    if (s && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction
  task automatic m_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) mdl[a + 32'(i)] = 8'(wd >> (8 * i));
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_if_done"}, 32'(b.if_done), 0);
    chk({nm, "_mem_done"}, 32'(b.mem_done), 0);
    chk({nm, "_if_inst"}, b.if_inst, 0);
    chk({nm, "_mem_rdata"}, b.mem_rdata, 0);
    chk({nm, "_ram_a"}, b.ram_a, 0);
    chk({nm, "_ram_wr"}, 32'(b.ram_wr), 0);
    chk({nm, "_ram_dout"}, 32'(b.ram_dout), 0);
    chk({nm, "_busy"}, 32'(b.busy), 0);
  endtask
  task automatic xact(input bit f, input bit we, input logic [1:0] len, input bit sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] d, output int lat);
    int n;
    bit ok, w;
    n = f ? 4 : nb(len);
    w = !f && we;
    @(posedge clk); #1;
    if (f) begin
      b.if_req = 1'b1; b.if_addr = a;
    end else begin
      b.mem_req = 1'b1; b.mem_we = we; b.mem_len = len; b.mem_sign = sg;
      b.mem_addr = a; b.mem_wdata = wd;
    end
    @(posedge clk); #1;
    b.if_addr = ~a; b.mem_addr = ~a; b.mem_wdata = ~wd; b.mem_sign = !sg;
    b.mem_len = ~len; b.mem_we = !we;
    ok = 1'b1;
    lat = 0;
    while (!(f ? b.if_done : b.mem_done) && lat < 12) begin
      if (lat < n)
        ok &= b.ram_a === a + 32'(lat) && b.ram_wr === w && b.busy === 1'b1 &&
              b.ram_dout === (w ? 8'(wd >> (8 * lat)) : 8'h00);
      else
        ok &= b.ram_a === 32'h0 && b.ram_wr === 1'b0 && b.ram_dout === 8'h00 && b.busy === 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk(f ? "fetch_bus_seq" : "mem_bus_seq", 32'(ok), 1);
    chk("done_cycle_quiet", 32'({b.busy, b.ram_wr, |b.ram_a, |b.ram_dout}), 0);
    d = f ? b.if_inst : b.mem_rdata;
    b.if_req = 1'b0;
    b.mem_req = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", 32'({b.if_done, b.mem_done}), 0);
  endtask
  typedef struct {
    bit f; bit we; logic [1:0] len; bit sg;
    logic [31:0] a; logic [31:0] wd; logic [31:0] ed; int el;
  } vec_t;
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
  initial begin
    vec_t tv[12];
    logic [31:0] d, prev, mv, fv, a2;
    int lat, k, mk, fk;
    bit seen, bb;
    b.if_req = 0; b.if_addr = 0; b.mem_req = 0; b.mem_we = 0; b.mem_len = 0;
    b.mem_sign = 0; b.mem_addr = 0; b.mem_wdata = 0;
    tv[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0,        32'h00100513, 5};
    tv[1]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h00000200, 32'h0,        32'hFFFFFF80, 2};
    tv[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h00000200, 32'h0,        32'h00000080, 2};
    tv[3]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h00000300, 32'hDEADBEEF, 32'h00000080, 4};
    tv[4]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h00000300, 32'h0,        32'hDEADBEEF, 5};
    tv[5]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h00000400, 32'h0,        32'hFFFF9234, 3};
    tv[6]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h00000400, 32'h0,        32'h00009234, 3};
    tv[7]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0,        32'h44332211, 5};
    tv[8]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h00000500, 32'h12345655, 32'h00009234, 1};
    tv[9]  = '{1'b0, 1'b0, 2'd2, 1'b1, 32'h00000500, 32'h0,        32'h00000055, 5};
    tv[10] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h00000600, 32'hCAFE1234, 32'h00000055, 2};
    tv[11] = '{1'b0, 1'b0, 2'd3, 1'b1, 32'h00000600, 32'h0,        32'h00001234, 5};
    pre(32'h100, 8'h13); pre(32'h101, 8'h05); pre(32'h102, 8'h10); pre(32'h103, 8'h00);
    pre(32'h200, 8'h80); pre(32'h400, 8'h34); pre(32'h401, 8'h92);
    pre(32'hFFFFFFFE, 8'h11); pre(32'hFFFFFFFF, 8'h22); pre(32'h0, 8'h33); pre(32'h1, 8'h44);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      xact(tv[i].f, tv[i].we, tv[i].len, tv[i].sg, tv[i].a, tv[i].wd, d, lat);
      chk($sformatf("vec%0d_data", i), d, tv[i].ed);
      chk($sformatf("vec%0d_lat", i), lat, tv[i].el);
      if (tv[i].we) m_store(tv[i].a, nb(tv[i].len), tv[i].wd);
    end
    @(posedge clk); #1;
    b.mem_req = 1; b.mem_we = 0; b.mem_len = 2'd1; b.mem_sign = 1; b.mem_addr = 32'h400;
    b.if_req = 1; b.if_addr = 32'h100;
    @(posedge clk); #1;
    a2 = b.ram_a;
    k = 0; mk = -1; fk = -1; bb = 0; mv = 0; fv = 0;
    while (fk < 0 && k < 30) begin
      @(posedge clk); #1;
      k++;
      if (mk >= 0 && k == mk + 1) begin
        bb = b.busy;
        chk("prio_if_addr", b.ram_a, 32'h100);
      end
      if (b.mem_done) begin mk = k; mv = b.mem_rdata; b.mem_req = 0; end
      if (b.if_done) begin fk = k; fv = b.if_inst; b.if_req = 0; end
    end
    b.mem_req = 0; b.if_req = 0;
    chk("prio_first_addr", a2, 32'h400);
    chk("prio_mem_edge", mk, 3);
    chk("prio_mem_data", mv, 32'hFFFF9234);
    chk("prio_b2b_busy", 32'(bb), 1);
    chk("prio_if_edge", fk, 9);
    chk("prio_if_data", fv, 32'h00100513);
    @(posedge clk); #1;
    b.if_req = 1; b.if_addr = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pre_busy", 32'(b.busy), 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; b.if_req = 0;
    chk_zero("rst_mid");
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (b.if_done) seen = 1;
    end
    chk("rst_no_done", 32'(seen), 0);
    xact(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, d, lat);
    chk("post_rst_inst", d, 32'h00100513);
    chk("post_rst_lat", lat, 5);
`ifdef MEMCTRL_FETCH_ABORT_EN
    @(posedge clk); #1;
    b.if_req = 1; b.if_addr = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if_abort = 1; b.if_req = 0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(b.busy), 0);
    chk("abort_done", 32'(b.if_done), 0);
    if_abort = 0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (b.if_done) seen = 1;
    end
    chk("abort_no_done", 32'(seen), 0);
    chk("abort_inst_kept", b.if_inst, 32'h00100513);
    if_abort = 1; b.if_req = 1; b.if_addr = 32'h300;
    @(posedge clk); #1;
    chk("abort_blocks_accept", 32'(b.busy), 0);
    b.if_req = 0;
    xact(1'b0, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, d, lat);
    chk("abort_mem_data", d, 32'hDEADBEEF);
    chk("abort_mem_lat", lat, 5);
    if_abort = 0;
`endif
    for (int i = 0; i < 68; i++) pre(32'h1000 + 32'(i), 8'($urandom));
    for (int i = 0; i < 4; i++) pre(32'hFFFFFFFC + 32'(i), 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      bit f, we, sg;
      logic [1:0] len;
      logic [31:0] a, wd;
      int n;
      f = $urandom_range(0, 3) == 0;
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      len = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                      : 32'h1000 + 32'($urandom_range(0, 63));
      wd = $urandom;
      n = f ? 4 : nb(len);
      prev = b.mem_rdata;
      xact(f, we, len, sg, a, wd, d, lat);
      if (f) begin
        chk("rnd_inst", d, m_load(a, 4, 1'b0));
        chk("rnd_lat", lat, 5);
      end else if (we) begin
        chk("rnd_st_keep", d, prev);
        chk("rnd_lat", lat, n);
        m_store(a, n, wd);
      end else begin
        chk("rnd_ld", d, m_load(a, n, sg));
        chk("rnd_lat", lat, n + 1);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbiter and sequencer for the single byte-wide RAM port shared by instruction fetch (IF) and the MEM stage (loads/stores whose address and store data come from the EX ALU result).
- Splits each 32-bit/16-bit/8-bit access into byte bus cycles.
- Assembles read data little-endian and sign/zero-extends loads.
- Returns a one-cycle done pulse to the winning requester.

Parameters:
- ADDR_W, 32, width of RAM byte address and of all request addresses.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- if_req  input  1  fetch request, held until if_done
- if_addr  input  ADDR_W  fetch byte address
- if_done  output  1  one-cycle pulse: if_inst valid
- if_inst  output  32  fetched instruction word
- mem_req  input  1  load/store request, held until mem_done
- mem_we  input  1  1=store, 0=load
- mem_len  input  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- mem_sign  input  1  loads only: 1=sign-extend, 0=zero-extend
- mem_addr  input  ADDR_W  base byte address (EX alu result)
- mem_wdata  input  32  store data (EX rdata2)
- mem_done  output  1  one-cycle pulse: access complete, mem_rdata valid for loads
- mem_rdata  output  32  extended load data
- ram_a  output  ADDR_W  RAM byte address
- ram_wr  output  1  1=write cycle
- ram_dout  output  8  write byte
- ram_din  input  8  read byte, valid one cycle after its address is driven
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst high at an edge): state=IDLE, byte counter=0. All outputs 0 (if_done, mem_done, if_inst, mem_rdata, ram_a, ram_wr, ram_dout, busy). Any in-flight access is dropped with no done pulse.
- States: IDLE, READ, WRITE. N = 1/2/4 bytes for byte/half/word; a fetch is always N=4.
- Acceptance: at an edge in IDLE. mem_req wins over if_req when both are high. A requester whose done is high in the current cycle is not accepted at that edge. Address, len, sign, we and wdata are latched on acceptance; later input changes are ignored.
- READ: bus cycles c=0..N.
  - Cycle c<N: ram_a=base+c, ram_wr=0.
  - Cycle c>=1: ram_din captured into result byte c-1, little-endian.
  - After cycle N: state=IDLE, and done plus data are registered high for the next cycle. Done therefore rises N+1 edges after the accept edge (word: 5).
- WRITE: bus cycles c=0..N-1: ram_wr=1, ram_a=base+c, ram_dout=wdata[8c+7:8c]. Done is high in the cycle after the last write cycle, N edges after acceptance. mem_rdata is unchanged by stores.
- Load extension: byte uses bit 7, half uses bit 15, per mem_sign. Word is passed through.
- Done pulses last exactly one cycle. if_inst and mem_rdata hold their values until the next completion of the same type.
- Address arithmetic is modulo 2^ADDR_W (wraps). No alignment check.
- IDLE and done cycles: ram_a=0, ram_wr=0, ram_dout=0.
- A new request may be accepted at the edge ending a done cycle (other requester only), giving back-to-back transactions with no idle gap.
- busy=1 in READ/WRITE and 0 in IDLE, including during done cycles.

Optional Feature:
- Macro MEMCTRL_FETCH_ABORT_EN.
- Defined: adds input port if_abort (1 bit, driven from the EX branch signal).
  - if_abort high at an edge while a fetch is in READ: the fetch is dropped, state=IDLE next cycle, no if_done, if_inst unchanged.
  - if_abort has no effect on MEM transactions.
  - if_abort and if_req both high in IDLE: the fetch is not accepted that edge.
- Undefined: no if_abort port; every accepted fetch runs to completion.

Test Plan:
- Word fetch, if_addr=0x00000100, RAM[0x100..0x103]=13,05,10,00 -> ram_a steps 0x100..0x103; if_done 5 edges after acceptance; if_inst=0x00100513.
- LB at 0x200 with RAM byte 0x80: mem_sign=1 -> mem_rdata=0xFFFFFF80; mem_sign=0 (LBU) -> 0x00000080. Each: done 2 edges after acceptance.
- SW 0xDEADBEEF at 0x300 -> 4 cycles with ram_wr=1, addresses 0x300..0x303, bytes EF,BE,AD,DE; mem_done in the 5th cycle; RAM then reads back 0xDEADBEEF via LW.
- if_req and mem_req (LH 0x400, RAM=0x34,0x92, signed) raised in the same IDLE cycle -> MEM served first, mem_rdata=0xFFFF9234; IF accepted at the edge ending the mem_done cycle; if_done follows 5 edges later.
- rst pulsed during READ cycle c=2 of a fetch -> all outputs 0 the next cycle, no if_done; a fresh fetch afterwards completes normally. Word fetch at 0xFFFFFFFE -> ram_a=0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- MEMCTRL_FETCH_ABORT_EN defined: if_abort at c=1 of a fetch -> busy=0 next cycle, no if_done, if_inst retains its old value.
